serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial subtractor, LSB first, with a start/busy/done handshake. It computes op_a - op_b one bit per clock using a registered borrow.
- It is the inverse-operation companion to the combinational switch adder on the board. The switch pairs supply the operands, and diff/borrow drive the LEDs.
- It also serves as the team's first sequential arithmetic block; later serial ALU work reuses its shift/count structure.

Parameters:
- WIDTH, 2, operand and result width in bits; legal range 1..16.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the block can accept (IDLE or DONE)
- op_a  input  WIDTH  minuend; captured on the accepting edge
- op_b  input  WIDTH  subtrahend; captured on the accepting edge
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when diff/borrow have just been updated
- diff  output  WIDTH  registered result, (op_a - op_b) mod 2^WIDTH
- borrow  output  1  registered result flag; 1 when op_a < op_b (unsigned)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow=0. Internal shift registers, bit counter and borrow FF are all cleared.
- rst high mid-operation aborts the operation. diff/borrow return to 0, no done pulse is produced, and the captured operands are discarded.
- State IDLE:
  - start=1 at an edge captures op_a/op_b into internal shift registers, clears the borrow FF and the bit counter, and moves to SHIFT.
  - start=0 stays in IDLE.
- State SHIFT, each edge:
  - Inputs to the bit step: a = sa[0], b = sb[0], bin = borrow FF.
  - d = a ^ b ^ bin.
  - bout = (~a & b) | (~(a ^ b) & bin).
  - d shifts into the MSB of the internal result register. sa and sb shift right by one. The borrow FF takes bout. The counter increments.
- Leaving SHIFT: on the edge processing bit WIDTH-1, diff takes the complete result (including the bit just computed), borrow takes the final bout, and the state moves to DONE.
- State DONE (exactly one cycle): done=1, busy=0.
  - Next edge returns to IDLE, unless start=1.
  - start=1 in DONE is accepted exactly as in IDLE. This gives back-to-back operation with no bubble beyond the DONE cycle.
- busy equals (state == SHIFT), registered.
- Latency: start sampled at edge k gives busy=1 after edges k..k+WIDTH-1 and done=1 after edge k+WIDTH only.
  - Throughput is one result per WIDTH+1 cycles.
- diff/borrow hold their last value until the next completing edge or reset. They never show partial results while busy.
- start while busy=1 is ignored: no queueing and no effect on the operation in flight.
- op_a/op_b changing after capture has no effect.
- Width rules:
  - Counter width is clog2(WIDTH)+1 bits.
  - WIDTH=1 is legal: a single SHIFT cycle, then DONE.
  - No sign interpretation is applied. borrow is the unsigned underflow flag, and diff is the two's-complement wrap value.

Test Plan:
- WIDTH=2, reset then op_a=3, op_b=1, start pulse at edge k -> busy=1 for 2 cycles; done=1 after edge k+2 with diff=2, borrow=0; done=0 one cycle later.
- WIDTH=2, op_a=1, op_b=2 -> diff=3, borrow=1. Then op_a=2, op_b=2 -> diff=0, borrow=0. Then op_a=0, op_b=3 -> diff=1, borrow=1.
- Hold start=1 continuously with alternating operand sets -> new operation accepted in every DONE cycle. done pulses every 3 cycles (WIDTH=2); each result matches its own operands; start during busy causes no corruption.
- Start 3-1, then change op_a/op_b and pulse start mid-SHIFT -> result still diff=2, borrow=0; no extra done pulse.
- Assert rst for one edge mid-SHIFT -> busy=0, done=0, diff=0, borrow=0 after that edge; no done pulse follows; a new start afterwards completes normally.
- WIDTH=8 and WIDTH=1 builds, 1000 random operand pairs -> diff == (a-b) mod 2^WIDTH and borrow == (a<b), each done exactly WIDTH edges after acceptance; the WIDTH=8 run includes corners 0-0, 0-255 (diff=1, borrow=1) and 255-0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = op_a - op_b, one bit per clock.
// start/busy/done handshake; results are registered and held between runs.
module serial_subtractor #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_bin;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;

   logic             w_a;
   logic             w_b;
   logic             w_d;
   logic             w_bout;
   logic             w_last;
   logic             w_accept;
   logic [WIDTH-1:0] w_res_nxt;

   assign w_a      = r_sa[0];
   assign w_b      = r_sb[0];
   assign w_d      = w_a ^ w_b ^ r_bin;
   assign w_bout   = (~w_a & w_b) | (~(w_a ^ w_b) & r_bin);
   assign w_last   = (r_cnt == LAST);
   assign w_accept = start && (r_state == IDLE || r_state == DONE);
   // New bit enters at the MSB so the LSB-first result lands aligned
   assign w_res_nxt = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (start) w_state_nxt = SHIFT;
         SHIFT:   if (w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = start ? SHIFT : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sa     <= '0;
         r_sb     <= '0;
         r_res    <= '0;
         r_cnt    <= '0;
         r_bin    <= 1'b0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
      end else if (w_accept) begin
         r_sa  <= op_a;
         r_sb  <= op_b;
         r_res <= '0;
         r_cnt <= '0;
         r_bin <= 1'b0;
      end else if (r_state == SHIFT) begin
         r_sa  <= r_sa >> 1;
         r_sb  <= r_sb >> 1;
         r_res <= w_res_nxt;
         r_bin <= w_bout;
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_diff   <= w_res_nxt;
            r_borrow <= w_bout;
         end
      end
   end

   assign busy   = (r_state == SHIFT);
   assign done   = (r_state == DONE);
   assign diff   = r_diff;
   assign borrow = r_borrow;

endmodule
